l1_mem_arbiter: RTL and testbench
=================================

Name: l1_mem_arbiter

Overview:
- Shares the single external memory port between the L1 instruction cache (line refills) and the L1 data cache (single-word loads and stores).
- Sits between the two cache controllers and the memory bus.
- Sequences the instruction-cache refill as a BLOCK_WORDS-beat burst, generating beat addresses and beat indices.
- Holds each grant for the whole transaction; one memory beat outstanding at a time.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- BLOCK_WORDS, 4, words per I-cache line (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- ic_req_i  in  1  I-cache refill request; held until ic_done_o
- ic_addr_i  in  ADDR_W  miss address (any word in the line)
- ic_gnt_o  out  1  I-cache owns the port
- ic_rvalid_o  out  1  refill word valid
- ic_beat_o  out  $clog2(BLOCK_WORDS)  word index of ic_rdata_o
- ic_rdata_o  out  DATA_W  refill word
- ic_done_o  out  1  last refill word; one-cycle pulse
- dc_req_i  in  1  D-cache request; held until dc_done_o
- dc_we_i  in  1  1 = store, 0 = load
- dc_addr_i  in  ADDR_W  word address
- dc_wdata_i  in  DATA_W  store data
- dc_gnt_o  out  1  D-cache owns the port
- dc_rdata_o  out  DATA_W  load data, valid with dc_done_o
- dc_done_o  out  1  transaction complete; one-cycle pulse
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ready_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; beat counter 0; round-robin pointer points to I-cache.
  - All outputs 0.
  - Reset mid-transaction abandons it; a later mem_rvalid_i for it is ignored.
- States: IDLE, IC_REQ, IC_WAIT, DC_REQ, DC_WAIT.
- IDLE:
  - Samples requests at each clock edge.
  - Only dc_req_i → DC_REQ. Only ic_req_i → IC_REQ. Both → priority rule (see Optional Feature).
  - Neither → stay in IDLE.
  - Request-to-mem_req_o latency is one cycle.
- Grant outputs: ic_gnt_o = state ∈ {IC_REQ, IC_WAIT}; dc_gnt_o = state ∈ {DC_REQ, DC_WAIT}. Both are state-decoded and never high together.
- IC_REQ:
  - mem_req_o = 1, mem_we_o = 0.
  - mem_addr_o = {ic_addr_i[ADDR_W-1 : log2(BLOCK_WORDS)+2], beat_cnt, 2'b00}.
  - On mem_ready_i → IC_WAIT.
- IC_WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i: ic_rvalid_o = 1, ic_rdata_o = mem_rdata_i, ic_beat_o = beat_cnt.
  - Not the last beat: beat_cnt increments, next state IC_REQ.
  - beat_cnt == BLOCK_WORDS-1: ic_done_o = 1 in the same cycle, beat_cnt clears to 0, next state IDLE.
- DC_REQ:
  - mem_req_o = 1, mem_we_o = dc_we_i, mem_addr_o = {dc_addr_i[ADDR_W-1:2], 2'b00}, mem_wdata_o = dc_wdata_i.
  - On mem_ready_i: store → dc_done_o = 1 that cycle, next state IDLE; load → DC_WAIT.
- DC_WAIT: on mem_rvalid_i, dc_done_o = 1 and dc_rdata_o = mem_rdata_i in the same cycle; next state IDLE.
- Outputs when invalid: mem_addr_o, mem_wdata_o, ic_rdata_o and dc_rdata_o are 0 whenever their valid qualifier is 0.
- mem_req_o is held with stable address and data until mem_ready_i.
- Request drop and re-request:
  - Dropping a request mid-transaction does not abort it.
  - A requester must deassert req by the edge ending its done cycle. A req high in IDLE is a new transaction.
- mem_rvalid_i in IDLE, IC_REQ or DC_REQ is ignored.
- mem_ready_i and mem_rvalid_i high together in *_REQ: only mem_ready_i is honoured.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register toggles priority on simultaneous requests; the side not granted last wins.
  - The register updates on every grant out of IDLE.
  - Reset value favours the I-cache.
- Undefined: fixed priority, D-cache always wins ties; the last-grant register is not instantiated.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (3-bit: IDLE, IC_REQ, IC_WAIT, DC_REQ, DC_WAIT).
  - requester_t enum (REQ_IC, REQ_DC).
  - Constant WORD_OFFSET_BITS = 2.
- Sub-module: none. Beat counter and priority pick stay inline.

Test Plan:
- I-cache refill, ic_addr_i=0x0000_1048, mem_ready_i=1 always, rvalid one cycle after accept → mem_addr_o 0x1040, 0x1044, 0x1048, 0x104C in order; ic_beat_o 0..3; ic_done_o with beat 3 only.
- D-cache store, addr 0x2000, wdata 0xDEADBEEF, mem_ready_i delayed 3 cycles → mem_req_o held 4 cycles with stable addr/data; dc_done_o pulses in the accept cycle; no DC_WAIT.
- ic_req_i and dc_req_i raised in the same cycle, both re-requested after done →
  - Without macro: D-cache is granted both times.
  - With ARB_ROUND_ROBIN_EN: grants go I-cache then D-cache.
- D-cache load requested during an I-cache burst at beat 1 → D-cache is granted only after ic_done_o; the I-cache burst is never interrupted.
- reset_i asserted in IC_WAIT at beat 2, then stray mem_rvalid_i → outputs 0 immediately; the stray rvalid produces no ic_rvalid_o; the next refill starts at beat 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the L1 memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IC_REQ  = 3'd1,
      IC_WAIT = 3'd2,
      DC_REQ  = 3'd3,
      DC_WAIT = 3'd4
   } arb_state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } requester_t;

   localparam int unsigned WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/l1_mem_arbiter.sv
// Arbitrates the external memory port between I-cache line refills and D-cache word accesses.
// Optional macro ARB_ROUND_ROBIN_EN: alternate tie priority instead of favouring the D-cache.
module l1_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           ic_req_i,
   input  logic [ADDR_W-1:0]              ic_addr_i,
   output logic                           ic_gnt_o,
   output logic                           ic_rvalid_o,
   output logic [$clog2(BLOCK_WORDS)-1:0] ic_beat_o,
   output logic [DATA_W-1:0]              ic_rdata_o,
   output logic                           ic_done_o,
   input  logic                           dc_req_i,
   input  logic                           dc_we_i,
   input  logic [ADDR_W-1:0]              dc_addr_i,
   input  logic [DATA_W-1:0]              dc_wdata_i,
   output logic                           dc_gnt_o,
   output logic [DATA_W-1:0]              dc_rdata_o,
   output logic                           dc_done_o,
   output logic                           mem_req_o,
   output logic                           mem_we_o,
   output logic [ADDR_W-1:0]              mem_addr_o,
   output logic [DATA_W-1:0]              mem_wdata_o,
   input  logic                           mem_ready_i,
   input  logic                           mem_rvalid_i,
   input  logic [DATA_W-1:0]              mem_rdata_i
);

   localparam int unsigned BEAT_W = $clog2(BLOCK_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

   arb_state_t        state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   requester_t        tie_winner;
   logic              grant_ic, grant_dc;

   // Offset bits below the line/word boundary never reach the memory bus.
   logic unused_addr;
   assign unused_addr = ^{ic_addr_i[BEAT_W+WORD_OFFSET_BITS-1:0],
                          dc_addr_i[WORD_OFFSET_BITS-1:0]};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   requester_t last_gnt_q, last_gnt_d;

   // Reset as if the D-cache was served last so the I-cache wins the first tie.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         last_gnt_q <= REQ_DC;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (grant_ic) begin
         last_gnt_d = REQ_IC;
      end else if (grant_dc) begin
         last_gnt_d = REQ_DC;
      end
   end

   assign tie_winner = (last_gnt_q == REQ_DC) ? REQ_IC : REQ_DC;
`else
   assign tie_winner = REQ_DC;
`endif

   assign ic_gnt_o = (state_q == IC_REQ) || (state_q == IC_WAIT);
   assign dc_gnt_o = (state_q == DC_REQ) || (state_q == DC_WAIT);

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      grant_ic    = 1'b0;
      grant_dc    = 1'b0;
      ic_rvalid_o = 1'b0;
      ic_beat_o   = '0;
      ic_rdata_o  = '0;
      ic_done_o   = 1'b0;
      dc_rdata_o  = '0;
      dc_done_o   = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      unique case (state_q)
         IDLE: begin
            if (ic_req_i && dc_req_i) begin
               grant_ic = (tie_winner == REQ_IC);
               grant_dc = (tie_winner == REQ_DC);
            end else begin
               grant_ic = ic_req_i;
               grant_dc = dc_req_i;
            end
            if (grant_ic) begin
               state_d = IC_REQ;
            end else if (grant_dc) begin
               state_d = DC_REQ;
            end
         end

         IC_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {ic_addr_i[ADDR_W-1:BEAT_W+WORD_OFFSET_BITS], beat_cnt_q,
                          {WORD_OFFSET_BITS{1'b0}}};
            if (mem_ready_i) begin
               state_d = IC_WAIT;
            end
         end

         IC_WAIT: begin
            if (mem_rvalid_i) begin
               ic_rvalid_o = 1'b1;
               ic_rdata_o  = mem_rdata_i;
               ic_beat_o   = beat_cnt_q;
               if (beat_cnt_q == LAST_BEAT) begin
                  ic_done_o  = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                  state_d    = IC_REQ;
               end
            end
         end

         DC_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = dc_we_i;
            mem_addr_o  = {dc_addr_i[ADDR_W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
            mem_wdata_o = dc_wdata_i;
            if (mem_ready_i) begin
               // Stores complete on acceptance; loads wait for read data.
               if (dc_we_i) begin
                  dc_done_o = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d = DC_WAIT;
               end
            end
         end

         DC_WAIT: begin
            if (mem_rvalid_i) begin
               dc_done_o  = 1'b1;
               dc_rdata_o = mem_rdata_i;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized transactions.
module tb_l1_mem_arbiter;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BLOCK_WORDS = 4;
   localparam int unsigned BEAT_W      = $clog2(BLOCK_WORDS);

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              ic_req_i;
   logic [ADDR_W-1:0] ic_addr_i;
   logic              ic_gnt_o, ic_rvalid_o, ic_done_o;
   logic [BEAT_W-1:0] ic_beat_o;
   logic [DATA_W-1:0] ic_rdata_o;
   logic              dc_req_i, dc_we_i;
   logic [ADDR_W-1:0] dc_addr_i;
   logic [DATA_W-1:0] dc_wdata_i;
   logic              dc_gnt_o, dc_done_o;
   logic [DATA_W-1:0] dc_rdata_o;
   logic              mem_req_o, mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ready_i, mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;
   // Reference arbitration state: which side wins the next simultaneous request.
   bit rr_favour_ic = 1'b1;

   always #5 clk_i = ~clk_i;

   l1_mem_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .ic_req_i     (ic_req_i),
      .ic_addr_i    (ic_addr_i),
      .ic_gnt_o     (ic_gnt_o),
      .ic_rvalid_o  (ic_rvalid_o),
      .ic_beat_o    (ic_beat_o),
      .ic_rdata_o   (ic_rdata_o),
      .ic_done_o    (ic_done_o),
      .dc_req_i     (dc_req_i),
      .dc_we_i      (dc_we_i),
      .dc_addr_i    (dc_addr_i),
      .dc_wdata_i   (dc_wdata_i),
      .dc_gnt_o     (dc_gnt_o),
      .dc_rdata_o   (dc_rdata_o),
      .dc_done_o    (dc_done_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ready_i  (mem_ready_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reference model pieces
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i);
      return (a & ~32'(BLOCK_WORDS * 4 - 1)) + 32'(4 * i);
   endfunction

   function automatic bit tie_goes_ic();
`ifdef ARB_ROUND_ROBIN_EN
      return rr_favour_ic;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void note_grant(input bit to_ic);
      rr_favour_ic = !to_ic;
   endfunction

   task automatic check_all_zero(input string tag);
      chk1({tag, "_ic_gnt"}, ic_gnt_o, 1'b0);
      chk1({tag, "_dc_gnt"}, dc_gnt_o, 1'b0);
      chk1({tag, "_mem_req"}, mem_req_o, 1'b0);
      chk1({tag, "_mem_we"}, mem_we_o, 1'b0);
      chkw({tag, "_mem_addr"}, mem_addr_o, 32'h0);
      chkw({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
      chk1({tag, "_ic_rvalid"}, ic_rvalid_o, 1'b0);
      chkw({tag, "_ic_rdata"}, ic_rdata_o, 32'h0);
      chkw({tag, "_ic_beat"}, 32'(ic_beat_o), 32'h0);
      chk1({tag, "_ic_done"}, ic_done_o, 1'b0);
      chkw({tag, "_dc_rdata"}, dc_rdata_o, 32'h0);
      chk1({tag, "_dc_done"}, dc_done_o, 1'b0);
   endtask

   // Called in the first IC_REQ cycle; returns one cycle after the done (or reset) cycle.
   task automatic serve_ic(input logic [31:0] addr, input bit rnd, input int inj_beat,
                           input int abort_beat);
      int d, r;
      logic [31:0] data;
      note_grant(1'b1);
      for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
         d = rnd ? int'($urandom_range(0, 2)) : 0;
         for (int k = 0; k <= d; k++) begin
            mem_ready_i = (k == d);
            if (i == inj_beat && k == 0) dc_req_i = 1'b1;
            #1;
            chk1("ic_req_gnt", ic_gnt_o, 1'b1);
            chk1("ic_req_dc_gnt", dc_gnt_o, 1'b0);
            chk1("ic_mem_req", mem_req_o, 1'b1);
            chk1("ic_mem_we", mem_we_o, 1'b0);
            chkw("ic_mem_addr", mem_addr_o, beat_addr(addr, i));
            chk1("ic_early_rvalid", ic_rvalid_o, 1'b0);
            tick();
         end
         mem_ready_i = 1'b0;
         if (i == abort_beat) begin
            #1;
            chk1("pre_rst_ic_gnt", ic_gnt_o, 1'b1);
            reset_i  = 1'b1;
            ic_req_i = 1'b0;
            #1;
            check_all_zero("rst_async");
            tick();
            reset_i      = 1'b0;
            rr_favour_ic = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom | 32'h1;
            #1;
            chk1("stray_ic_rvalid", ic_rvalid_o, 1'b0);
            chkw("stray_ic_rdata", ic_rdata_o, 32'h0);
            chk1("stray_ic_gnt", ic_gnt_o, 1'b0);
            chk1("stray_mem_req", mem_req_o, 1'b0);
            tick();
            mem_rvalid_i = 1'b0;
            return;
         end
         r = rnd ? int'($urandom_range(0, 2)) : 0;
         for (int k = 0; k <= r; k++) begin
            data         = $urandom;
            mem_rvalid_i = (k == r);
            mem_rdata_i  = data;
            if (k == r && i == int'(BLOCK_WORDS) - 1) ic_req_i = 1'b0;
            #1;
            chk1("ic_wait_gnt", ic_gnt_o, 1'b1);
            chk1("ic_wait_mem_req", mem_req_o, 1'b0);
            chkw("ic_wait_mem_addr", mem_addr_o, 32'h0);
            chk1("ic_rvalid", ic_rvalid_o, k == r);
            chkw("ic_rdata", ic_rdata_o, (k == r) ? data : 32'h0);
            chkw("ic_beat", 32'(ic_beat_o), (k == r) ? 32'(i) : 32'h0);
            chk1("ic_done", ic_done_o, (k == r) && (i == int'(BLOCK_WORDS) - 1));
            tick();
         end
         mem_rvalid_i = 1'b0;
      end
      #1;
      chk1("ic_after_done_gnt", ic_gnt_o, 1'b0);
   endtask

   // Called in the first DC_REQ cycle; delay < 0 picks a random accept delay.
   task automatic serve_dc(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay);
      int d, r;
      logic [31:0] data;
      note_grant(1'b0);
      d = (delay >= 0) ? delay : int'($urandom_range(0, 2));
      for (int k = 0; k <= d; k++) begin
         mem_ready_i = (k == d);
         if (we && k == d) dc_req_i = 1'b0;
         #1;
         chk1("dc_gnt", dc_gnt_o, 1'b1);
         chk1("dc_ic_gnt", ic_gnt_o, 1'b0);
         chk1("dc_mem_req", mem_req_o, 1'b1);
         chk1("dc_mem_we", mem_we_o, we);
         chkw("dc_mem_addr", mem_addr_o, addr & ~32'h3);
         if (we) chkw("dc_mem_wdata", mem_wdata_o, wdata);
         chk1("dc_done_req", dc_done_o, we && (k == d));
         tick();
      end
      mem_ready_i = 1'b0;
      if (!we) begin
         r = int'($urandom_range(0, 2));
         for (int k = 0; k <= r; k++) begin
            data         = $urandom;
            mem_rvalid_i = (k == r);
            mem_rdata_i  = data;
            if (k == r) dc_req_i = 1'b0;
            #1;
            chk1("dc_wait_gnt", dc_gnt_o, 1'b1);
            chk1("dc_wait_mem_req", mem_req_o, 1'b0);
            chkw("dc_wait_mem_addr", mem_addr_o, 32'h0);
            chk1("dc_done_load", dc_done_o, k == r);
            chkw("dc_rdata", dc_rdata_o, (k == r) ? data : 32'h0);
            tick();
         end
         mem_rvalid_i = 1'b0;
      end
      #1;
      chk1("dc_after_done_gnt", dc_gnt_o, 1'b0);
   endtask

   task automatic start_dc(output bit we, output logic [31:0] addr, output logic [31:0] wd);
      we   = $urandom_range(0, 1) == 1;
      addr = $urandom;
      wd   = $urandom;
      dc_we_i    = we;
      dc_addr_i  = addr;
      dc_wdata_i = wd;
      dc_req_i   = 1'b1;
   endtask

   // Both sides request in the same cycle; the loser keeps requesting and is served next.
   task automatic tie_round();
      bit          we, exp_ic;
      logic [31:0] da, wd, ia;
      ia        = $urandom;
      ic_addr_i = ia;
      ic_req_i  = 1'b1;
      start_dc(we, da, wd);
      exp_ic = tie_goes_ic();
      tick();
      chk1("tie_ic_gnt", ic_gnt_o, exp_ic);
      chk1("tie_dc_gnt", dc_gnt_o, !exp_ic);
      if (exp_ic) begin
         serve_ic(ia, 1'b1, -1, -1);
         tick();
         serve_dc(we, da, wd, -1);
      end else begin
         serve_dc(we, da, wd, -1);
         tick();
         serve_ic(ia, 1'b1, -1, -1);
      end
   endtask

   initial begin
      bit          we;
      logic [31:0] da, wd, ia;

      reset_i      = 1'b1;
      ic_req_i     = 1'b0;
      ic_addr_i    = '0;
      dc_req_i     = 1'b0;
      dc_we_i      = 1'b0;
      dc_addr_i    = '0;
      dc_wdata_i   = '0;
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      #1;
      check_all_zero("reset");
      tick();
      tick();
      reset_i = 1'b0;

      // Directed refill: ready always high, rvalid one cycle after acceptance.
      ic_addr_i = 32'h0000_1048;
      ic_req_i  = 1'b1;
      #1;
      chk1("latency_ic_gnt", ic_gnt_o, 1'b0);
      chk1("latency_mem_req", mem_req_o, 1'b0);
      tick();
      serve_ic(32'h0000_1048, 1'b0, -1, -1);

      // Directed store with acceptance delayed three cycles.
      dc_we_i    = 1'b1;
      dc_addr_i  = 32'h0000_2000;
      dc_wdata_i = 32'hDEAD_BEEF;
      dc_req_i   = 1'b1;
      tick();
      serve_dc(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3);

      // Simultaneous requests, twice.
      tie_round();
      tie_round();

      // D-cache load raised during beat 1 of a refill waits for the whole burst.
      dc_we_i   = 1'b0;
      dc_addr_i = 32'h0000_3004;
      ia        = 32'h0000_5010;
      ic_addr_i = ia;
      ic_req_i  = 1'b1;
      tick();
      serve_ic(ia, 1'b1, 1, -1);
      chk1("inj_idle_dc_gnt", dc_gnt_o, 1'b0);
      tick();
      serve_dc(1'b0, 32'h0000_3004, 32'h0, -1);

      // Reset during beat 2, stray read data, then a fresh refill from beat 0.
      ia        = 32'h0000_7fcc;
      ic_addr_i = ia;
      ic_req_i  = 1'b1;
      tick();
      serve_ic(ia, 1'b0, -1, 2);
      ia        = 32'h0000_8008;
      ic_addr_i = ia;
      ic_req_i  = 1'b1;
      tick();
      serve_ic(ia, 1'b0, -1, -1);

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 2))
            0: begin
               ia        = $urandom;
               ic_addr_i = ia;
               ic_req_i  = 1'b1;
               tick();
               serve_ic(ia, 1'b1, -1, -1);
            end
            1: begin
               start_dc(we, da, wd);
               tick();
               serve_dc(we, da, wd, -1);
            end
            default: tie_round();
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
